// File: rtl/ibex_pkg.sv
// ibex_pkg -- shared types for the hardware interrupt stacking sequencer.
//   hw_stacking_mode_t : direction requested from the stacking unit.
//   hws_seq_state_e    : sequencer FSM state encoding.
//   HWS_MAX_NEST       : default maximum interrupt nesting depth.
package ibex_pkg;

    localparam int HWS_MAX_NEST = 4;

    typedef enum logic {
        HWS_SAVE    = 1'b0,
        HWS_RESTORE = 1'b1
    } hw_stacking_mode_t;

    typedef enum logic [2:0] {
        SEQ_RUN           = 3'd0,
        SEQ_SAVE_START    = 3'd1,
        SEQ_SAVE_WAIT     = 3'd2,
        SEQ_RESTORE_START = 3'd3,
        SEQ_RESTORE_WAIT  = 3'd4,
        SEQ_HWS_ACK       = 3'd5,
        SEQ_DISPATCH      = 3'd6
    } hws_seq_state_e;

endpackage

// File: rtl/rt_ibex_hws_level_stack.sv
// rt_ibex_hws_level_stack -- LIFO of running interrupt levels.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   i_push          : push i_level (ignored when full)
//   i_pop           : drop top entry (ignored when empty)
//   i_replace_top   : overwrite top entry with i_level (ignored when empty)
//   o_top           : top entry, 0 when empty
//   o_below_top     : entry below top, 0 when depth < 2
//   o_depth         : number of valid entries
module rt_ibex_hws_level_stack
    import ibex_pkg::*;
#(
    parameter int MaxNest = HWS_MAX_NEST,
    parameter int LevelW  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_replace_top,
    input  logic [LevelW-1:0] i_level,
    output logic [LevelW-1:0] o_top,
    output logic [LevelW-1:0] o_below_top,
    output logic [2:0]        o_depth
);

    logic [LevelW-1:0] r_stack [MaxNest];
    logic [2:0]        r_depth;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_depth <= 3'd0;
            for (int i = 0; i < MaxNest; i++) r_stack[i] <= '0;
        end else if (i_push && (int'(r_depth) < MaxNest)) begin
            for (int i = 0; i < MaxNest; i++)
                if (3'(i) == r_depth) r_stack[i] <= i_level;
            r_depth <= r_depth + 3'd1;
        end else if (i_pop && (r_depth != 3'd0)) begin
            // Popped entries are cleared so stale levels never reappear.
            for (int i = 0; i < MaxNest; i++)
                if (3'(i + 1) == r_depth) r_stack[i] <= '0;
            r_depth <= r_depth - 3'd1;
        end else if (i_replace_top && (r_depth != 3'd0)) begin
            for (int i = 0; i < MaxNest; i++)
                if (3'(i + 1) == r_depth) r_stack[i] <= i_level;
        end
    end

    // Mux loops avoid out-of-range indexing when depth is 0 or 1.
    always_comb begin
        o_top       = '0;
        o_below_top = '0;
        for (int i = 0; i < MaxNest; i++) begin
            if (3'(i + 1) == r_depth) o_top       = r_stack[i];
            if (3'(i + 2) == r_depth) o_below_top = r_stack[i];
        end
    end

    assign o_depth = r_depth;

endmodule

// File: rtl/rt_ibex_hws_sequencer.sv
// rt_ibex_hws_sequencer -- sequences hardware register stacking around
// interrupt entry and mret, with nesting and tail-chaining.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   irq_req_i/id/level: pending enabled interrupt
//   mret_i            : one-cycle pulse, mret retiring
//   hws_done_i        : stacking unit finished
//   hws_start_o/mode  : start request and direction to stacking unit
//   hws_ack_o         : one-cycle acknowledge of hws_done_i
//   fetch_halt_o      : stall fetch/ID while not in RUN
//   irq_ack_o/id      : interrupt claim pulse and claimed id
//   handler_start_o   : redirect to handler vector
//   depth_o, cur_level_o : nesting depth and running level
//   spurious_mret_o   : mret seen at depth 0
// Handshake: hws_start_o is a one-cycle request; the stacking unit answers
// with hws_done_i (sampled only in *_WAIT), which is closed by a one-cycle
// hws_ack_o. There is no back-pressure on any pulse output.
module rt_ibex_hws_sequencer
    import ibex_pkg::*;
#(
    parameter int MaxNest = HWS_MAX_NEST,
    parameter int LevelW  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              irq_req_i,
    input  logic [4:0]        irq_id_i,
    input  logic [LevelW-1:0] irq_level_i,
    input  logic              mret_i,
    input  logic              hws_done_i,
    output logic              hws_start_o,
    output hw_stacking_mode_t hws_mode_o,
    output logic              hws_ack_o,
    output logic              fetch_halt_o,
    output logic              irq_ack_o,
    output logic [4:0]        irq_ack_id_o,
    output logic              handler_start_o,
    output logic [2:0]        depth_o,
    output logic [LevelW-1:0] cur_level_o,
    output logic              spurious_mret_o
);

    hws_seq_state_e    r_state, w_next_state;
    hw_stacking_mode_t r_mode, w_next_mode;
    logic [4:0]        r_id;
    logic [LevelW-1:0] r_level;
    logic              r_chain, r_spurious;

    logic              w_latch, w_chain, w_spurious;
    logic              w_push, w_pop, w_replace;
    logic [LevelW-1:0] w_top, w_below_top;
    logic [2:0]        w_depth;
    logic              w_qualify, w_tail_chain;

    rt_ibex_hws_level_stack #(
        .MaxNest (MaxNest),
        .LevelW  (LevelW)
    ) u_level_stack (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_replace_top (w_replace),
        .i_level       (r_level),
        .o_top         (w_top),
        .o_below_top   (w_below_top),
        .o_depth       (w_depth)
    );

    assign w_qualify    = irq_req_i && (irq_level_i > w_top) && (int'(w_depth) < MaxNest);
    // Tail-chain only needs to beat the level the mret would return to.
    assign w_tail_chain = irq_req_i && (irq_level_i > w_below_top);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= SEQ_RUN;
            r_mode     <= HWS_SAVE;
            r_id       <= 5'd0;
            r_level    <= '0;
            r_chain    <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_mode     <= w_next_mode;
            r_spurious <= w_spurious;
            if (w_latch) begin
                r_id    <= irq_id_i;
                r_level <= irq_level_i;
                r_chain <= w_chain;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_mode  = r_mode;
        w_latch      = 1'b0;
        w_chain      = 1'b0;
        w_spurious   = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_replace    = 1'b0;
        case (r_state)
            SEQ_RUN: begin
                if (mret_i) begin
                    if (w_depth == 3'd0) begin
                        w_spurious = 1'b1;
                    end else if (w_tail_chain) begin
                        w_next_state = SEQ_DISPATCH;
                        w_latch      = 1'b1;
                        w_chain      = 1'b1;
                    end else begin
                        w_next_state = SEQ_RESTORE_START;
                        w_next_mode  = HWS_RESTORE;
                    end
                end else if (w_qualify) begin
                    w_next_state = SEQ_SAVE_START;
                    w_latch      = 1'b1;
                end
            end
            SEQ_SAVE_START:    w_next_state = SEQ_SAVE_WAIT;
            SEQ_SAVE_WAIT:     if (hws_done_i) w_next_state = SEQ_HWS_ACK;
            SEQ_RESTORE_START: w_next_state = SEQ_RESTORE_WAIT;
            SEQ_RESTORE_WAIT:  if (hws_done_i) w_next_state = SEQ_HWS_ACK;
            SEQ_HWS_ACK: begin
                w_next_mode = HWS_SAVE;
                if (r_mode == HWS_RESTORE) begin
                    w_pop        = 1'b1;
                    w_next_state = SEQ_RUN;
                end else begin
                    w_next_state = SEQ_DISPATCH;
                end
            end
            SEQ_DISPATCH: begin
                w_push       = !r_chain;
                w_replace    = r_chain;
                w_next_state = SEQ_RUN;
            end
            default: w_next_state = SEQ_RUN;
        endcase
    end

    assign hws_start_o     = (r_state == SEQ_SAVE_START) || (r_state == SEQ_RESTORE_START);
    assign hws_mode_o      = r_mode;
    assign hws_ack_o       = (r_state == SEQ_HWS_ACK);
    assign fetch_halt_o    = (r_state != SEQ_RUN);
    assign irq_ack_o       = (r_state == SEQ_SAVE_START) || ((r_state == SEQ_DISPATCH) && r_chain);
    assign irq_ack_id_o    = r_id;
    assign handler_start_o = (r_state == SEQ_DISPATCH);
    assign depth_o         = w_depth;
    assign cur_level_o     = w_top;
    assign spurious_mret_o = r_spurious;

endmodule

// File: tb/tb_rt_ibex_hws_sequencer.sv
module tb_rt_ibex_hws_sequencer;
    import ibex_pkg::*;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              irq_req = 1'b0;
    logic [4:0]        irq_id = 5'd0;
    logic [7:0]        irq_level = 8'd0;
    logic              mret = 1'b0;
    logic              hws_done = 1'b0;
    logic              hws_start, hws_ack, fetch_halt, irq_ack, handler_start, spurious;
    hw_stacking_mode_t hws_mode;
    logic [4:0]        irq_ack_id;
    logic [2:0]        depth;
    logic [7:0]        cur_level;
    logic [6:0]        obs;

    int n_tests = 0;
    int n_fail  = 0;

    rt_ibex_hws_sequencer #(.MaxNest(4), .LevelW(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .irq_req_i       (irq_req),
        .irq_id_i        (irq_id),
        .irq_level_i     (irq_level),
        .mret_i          (mret),
        .hws_done_i      (hws_done),
        .hws_start_o     (hws_start),
        .hws_mode_o      (hws_mode),
        .hws_ack_o       (hws_ack),
        .fetch_halt_o    (fetch_halt),
        .irq_ack_o       (irq_ack),
        .irq_ack_id_o    (irq_ack_id),
        .handler_start_o (handler_start),
        .depth_o         (depth),
        .cur_level_o     (cur_level),
        .spurious_mret_o (spurious)
    );

    // {start, mode, hws_ack, fetch_halt, irq_ack, handler_start, spurious}
    assign obs = {hws_start, logic'(hws_mode), hws_ack, fetch_halt, irq_ack, handler_start, spurious};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [6:0] exp_obs,
                               input logic [2:0] exp_depth, input logic [7:0] exp_level);
        n_tests++;
        if (obs !== exp_obs || depth !== exp_depth || cur_level !== exp_level) begin
            n_fail++;
            $display("FAIL %s: outputs=%b depth=%0d level=%0d, expected outputs=%b depth=%0d level=%0d",
                     name, obs, depth, cur_level, exp_obs, exp_depth, exp_level);
        end
    endtask

    // Full interrupt entry from RUN; depth d, level lv before the call.
    task automatic do_save(input string name, input logic [4:0] id, input logic [7:0] lvl,
                           input int wait_cycles, input logic [2:0] d, input logic [7:0] lv);
        irq_req = 1'b1; irq_id = id; irq_level = lvl;
        tick();
        irq_req = 1'b0;
        check_state({name, "_save_start"}, 7'b1001100, d, lv);
        n_tests++;
        if (irq_ack_id !== id) begin
            n_fail++;
            $display("FAIL %s_ack_id: got %0d expected %0d", name, irq_ack_id, id);
        end
        tick();
        check_state({name, "_save_wait"}, 7'b0001000, d, lv);
        repeat (wait_cycles) tick();
        check_state({name, "_still_wait"}, 7'b0001000, d, lv);
        hws_done = 1'b1;
        tick();
        hws_done = 1'b0;
        check_state({name, "_hws_ack"}, 7'b0011000, d, lv);
        tick();
        check_state({name, "_dispatch"}, 7'b0001010, d, lv);
        tick();
        check_state({name, "_run"}, 7'b0000000, d + 3'd1, lvl);
    endtask

    // Full mret restore from RUN.
    task automatic do_restore(input string name, input logic [2:0] d, input logic [7:0] lv,
                              input logic [7:0] lv_after);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check_state({name, "_restore_start"}, 7'b1101000, d, lv);
        tick();
        check_state({name, "_restore_wait"}, 7'b0101000, d, lv);
        repeat (3) tick();
        hws_done = 1'b1;
        tick();
        hws_done = 1'b0;
        check_state({name, "_hws_ack"}, 7'b0111000, d, lv);
        tick();
        check_state({name, "_run"}, 7'b0000000, d - 3'd1, lv_after);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        check_state("reset", 7'b0000000, 3'd0, 8'd0);
        n_tests++;
        if (irq_ack_id !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_ack_id: got %0d expected 0", irq_ack_id);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_first_save();
        // 2 + 10 + done cycle = done seen 12 cycles after the claim edge.
        do_save("first", 5'd3, 8'd5, 10, 3'd0, 8'd0);
    endtask

    task automatic test_equal_level();
        irq_req = 1'b1; irq_id = 5'd1; irq_level = 8'd5;
        repeat (3) tick();
        check_state("equal_level_no_claim", 7'b0000000, 3'd1, 8'd5);
        irq_req = 1'b0;
    endtask

    task automatic test_nested();
        do_save("nested", 5'd7, 8'd6, 2, 3'd1, 8'd5);
    endtask

    task automatic test_restore();
        do_restore("restore", 3'd2, 8'd6, 8'd5);
    endtask

    task automatic test_tail_chain();
        mret = 1'b1; irq_req = 1'b1; irq_id = 5'd9; irq_level = 8'd2;
        tick();
        mret = 1'b0; irq_req = 1'b0;
        check_state("tail_dispatch", 7'b0001110, 3'd1, 8'd5);
        n_tests++;
        if (irq_ack_id !== 5'd9) begin
            n_fail++;
            $display("FAIL tail_ack_id: got %0d expected 9", irq_ack_id);
        end
        tick();
        check_state("tail_run", 7'b0000000, 3'd1, 8'd2);
    endtask

    task automatic test_depth_limit();
        do_save("fill3", 5'd10, 8'd3, 1, 3'd1, 8'd2);
        do_save("fill4", 5'd11, 8'd4, 1, 3'd2, 8'd3);
        do_save("fill5", 5'd12, 8'd5, 1, 3'd3, 8'd4);
        irq_req = 1'b1; irq_id = 5'd31; irq_level = 8'hFF;
        repeat (3) tick();
        check_state("full_no_claim", 7'b0000000, 3'd4, 8'd5);
        irq_req = 1'b0;
    endtask

    task automatic test_reset_mid_save();
        do_restore("pre_reset", 3'd4, 8'd5, 8'd4);
        irq_req = 1'b1; irq_id = 5'd4; irq_level = 8'd200;
        tick();
        irq_req = 1'b0;
        tick();
        check_state("mid_save_wait", 7'b0001000, 3'd3, 8'd4);
        rst_ni = 1'b0;
        tick();
        check_state("mid_reset", 7'b0000000, 3'd0, 8'd0);
        rst_ni = 1'b1;
        tick();
        check_state("after_reset", 7'b0000000, 3'd0, 8'd0);
    endtask

    task automatic test_spurious();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check_state("spurious_pulse", 7'b0000001, 3'd0, 8'd0);
        tick();
        check_state("spurious_clear", 7'b0000000, 3'd0, 8'd0);
    endtask

    initial begin
        test_reset();
        test_first_save();
        test_equal_level();
        test_nested();
        test_restore();
        test_tail_chain();
        test_depth_limit();
        test_reset_mid_save();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rt_ibex_hws_sequencer.md
RT_IBEX_HWS_SEQUENCER -- requirements
Module: rt_ibex_hws_sequencer

Interface
REQ-001 SHALL have parameter MaxNest, default 4, maximum interrupt nesting depth (1..7).
REQ-002 SHALL have parameter LevelW, default 8, interrupt level width.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports, in this order:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- irq_req_i  in  1  enabled interrupt pending.
- irq_id_i  in  5  pending interrupt id.
- irq_level_i  in  LevelW  pending interrupt level.
- mret_i  in  1  one-cycle pulse, mret retiring.
- hws_done_i  in  1  stacking unit done (registered there, lags one cycle).
- hws_start_o  out  1  one-cycle start to stacking unit.
- hws_mode_o  out  hw_stacking_mode_t  SAVE/RESTORE.
- hws_ack_o  out  1  one-cycle done acknowledge.
- fetch_halt_o  out  1  stall fetch/ID while stacking.
- irq_ack_o  out  1  one-cycle interrupt claim.
- irq_ack_id_o  out  5  id claimed, valid with irq_ack_o.
- handler_start_o  out  1  one-cycle redirect to handler vector.
- depth_o  out  3  current nesting depth.
- cur_level_o  out  LevelW  running level (0 when depth 0).
- spurious_mret_o  out  1  one-cycle pulse, mret at depth 0.

Function
REQ-005 SHALL implement FSM states RUN, SAVE_START, SAVE_WAIT, RESTORE_START, RESTORE_WAIT, HWS_ACK, DISPATCH.
REQ-006 SHALL keep a level stack of MaxNest entries; cur_level_o = top entry, or 0 at depth 0.
REQ-007 Qualifying irq: irq_req_i and irq_level_i > cur_level_o and depth_o < MaxNest.
REQ-008 In RUN, qualifying irq without mret_i SHALL go to SAVE_START; id/level latched at that edge.
REQ-009 SAVE_START (1 cycle): hws_start_o=1, hws_mode_o=SAVE, irq_ack_o=1, irq_ack_id_o=latched id; then SAVE_WAIT.
REQ-010 In RUN, mret_i at depth>0 without tail-chain SHALL go to RESTORE_START (hws_start_o=1, mode RESTORE), then RESTORE_WAIT.
REQ-011 Tail-chain: mret_i and irq_req_i in RUN with irq_level_i > level of entry below top (0 if depth 1) SHALL skip restore/save: DISPATCH next, top entry replaced by latched level, irq_ack_o=1 in DISPATCH cycle, depth unchanged.
REQ-012 In the same RUN cycle, mret_i SHALL take priority over a non-tail-chaining irq; the irq is re-evaluated in RUN after restore.
REQ-013 SAVE_WAIT/RESTORE_WAIT SHALL wait for hws_done_i=1, then go to HWS_ACK.
REQ-014 HWS_ACK (1 cycle): hws_ack_o=1; after save → DISPATCH; after restore → pop stack, → RUN.
REQ-015 DISPATCH (1 cycle): handler_start_o=1; after save, push latched level, depth+1; → RUN.
REQ-016 hws_done_i SHALL be ignored in HWS_ACK, DISPATCH and the first RUN cycle after HWS_ACK.
REQ-017 hws_mode_o SHALL be held constant from *_START through HWS_ACK; SAVE otherwise.
REQ-018 fetch_halt_o SHALL be 1 in every state except RUN.
REQ-019 irq_req_i and mret_i SHALL be ignored outside RUN.
REQ-020 mret_i at depth 0 SHALL pulse spurious_mret_o next cycle, no state change.
REQ-021 irq at depth==MaxNest SHALL not be claimed; stays pending.

Reset
REQ-022 On rst_ni=0 at clock edge: state RUN, depth 0, stack cleared, latched id/level 0, all pulse outputs 0, hws_mode_o=SAVE, fetch_halt_o=0.
REQ-023 Reset mid-sequence SHALL abort without hws_ack_o; stacking unit is reset by the same rst_ni.

Structure
REQ-024 hw_stacking_mode_t and sequencer state enum SHALL live in ibex_pkg; MaxNest default constant there.
REQ-025 Level stack SHALL be sub-module rt_ibex_hws_level_stack (push/pop/replace_top, top, below_top, depth).

Verification
REQ-026 Depth 0, irq id 3 level 5 → SAVE_START next cycle, irq_ack_id_o=3; done after 12 cycles → ack, handler_start_o, depth 1, cur_level 5.
REQ-027 Depth 1 level 5, irq level 5 → not claimed; level 6 → nested save, depth 2, cur_level 6.
REQ-028 Depth 1, mret_i with irq level 2 → tail-chain: no hws_start_o, DISPATCH, irq_ack_o, cur_level 2, depth 1.
REQ-029 Depth 2 (5,6), mret_i, no irq → RESTORE start/done/ack, depth 1, cur_level 5, fetch_halt_o low after.
REQ-030 Depth 4, irq level 255 → no claim; mret_i at depth 0 → spurious_mret_o one pulse.
REQ-031 rst_ni low during SAVE_WAIT → next cycle RUN, depth 0, all outputs at reset values.
